// File: rtl/x2c_bcnt_reader.sv
// x2c_bcnt_reader: pops one byte count per packet from the byte-count FIFO,
// pulls ceil(count/8) words from the data FIFO and presents them as a framed
// valid/ready stream (sop/eop/byte enables) through a 2-entry skid buffer.
//
// state | meaning
// IDLE  | waiting for a byte-count entry; rdreq follows !bcnt_empty
// LEN   | byte count on bcnt_q; validate and load the word counter
// DAT   | issuing data reads; leave once the eop word is accepted
module x2c_bcnt_reader #(
  parameter int DWIDTH    = 64,
  parameter int BCW       = 32,
  parameter int MAX_BYTES = 9600
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              bcnt_empty,
  output logic              bcnt_rdreq,
  input  logic [BCW-1:0]    bcnt_q,
  input  logic              data_empty,
  output logic              data_rdreq,
  input  logic [DWIDTH-1:0] data_q,
  output logic [DWIDTH-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic [7:0]        tx_be,
  output logic              bcnt_err,
  output logic [15:0]       pkt_cnt
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_BYTES);

  typedef enum logic [1:0] {ST_IDLE, ST_LEN, ST_DAT} state_t;

  typedef struct packed {
    logic [DWIDTH-1:0] data;
    logic              sop;
    logic              eop;
    logic [7:0]        be;
  } word_t;

  state_t      state_q, state_d;
  logic [13:0] words_left_q, words_left_d;
  logic [2:0]  rem_q, rem_d;
  logic        first_q, first_d;
  logic        inf_q, inf_d;
  logic        inf_sop_q, inf_sop_d;
  logic        inf_eop_q, inf_eop_d;
  logic [7:0]  inf_be_q, inf_be_d;
  word_t       buf_q [2];
  word_t       buf_d [2];
  logic [1:0]  occ_q, occ_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  logic [15:0] len;
  logic [16:0] len_p7;
  logic        len_bad;
  logic [7:0]  last_be;
  word_t       arr_w;
  word_t       head;
  logic        pop;
  logic        room;
  logic        unused_bcnt_hi;

  // Upper half of the byte-count entry is reserved.
  assign unused_bcnt_hi = ^bcnt_q[BCW-1:16];

  assign len     = bcnt_q[15:0];
  assign len_p7  = {1'b0, len} + 17'd7;
  assign len_bad = (len == 16'd0) || (len > MAX_LEN);
  assign last_be = (rem_q == 3'd0) ? 8'hFF : ~(8'hFF << rem_q);
  assign pkt_cnt = pkt_cnt_q;

  // Head of the stream: oldest stored word, else the word arriving from the FIFO this cycle.
  always_comb begin
    arr_w    = {data_q, inf_sop_q, inf_eop_q, inf_be_q};
    head     = '0;
    if (occ_q != 2'd0) begin
      head = buf_q[0];
    end else if (inf_q) begin
      head = arr_w;
    end
    tx_valid = (occ_q != 2'd0) | inf_q;
    pop      = tx_valid & tx_ready;
    tx_data  = head.data;
    tx_sop   = head.sop;
    tx_eop   = head.eop;
    tx_be    = head.be;
    // Stored + arriving words after this cycle's pop must leave a slot for the next read.
    room     = ({1'b0, occ_q} + {2'b00, inf_q}) < (3'd2 + {2'b00, pop});
  end

  // Next-state logic, FIFO read requests and word tagging.
  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    rem_d        = rem_q;
    first_d      = first_q;
    inf_d        = 1'b0;
    inf_sop_d    = inf_sop_q;
    inf_eop_d    = inf_eop_q;
    inf_be_d     = inf_be_q;
    pkt_cnt_d    = pkt_cnt_q;
    bcnt_rdreq   = 1'b0;
    data_rdreq   = 1'b0;
    bcnt_err     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!bcnt_empty && reset_) begin
          bcnt_rdreq = 1'b1;
          state_d    = ST_LEN;
        end
      end
      ST_LEN: begin
        if (len_bad) begin
          bcnt_err = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          words_left_d = len_p7[16:3];
          rem_d        = len[2:0];
          first_d      = 1'b1;
          state_d      = ST_DAT;
        end
      end
      ST_DAT: begin
        if ((words_left_q != 14'd0) && !data_empty && room && reset_) begin
          data_rdreq   = 1'b1;
          words_left_d = words_left_q - 14'd1;
          first_d      = 1'b0;
          inf_d        = 1'b1;
          inf_sop_d    = first_q;
          inf_eop_d    = (words_left_q == 14'd1);
          inf_be_d     = (words_left_q == 14'd1) ? last_be : 8'hFF;
        end
        if ((words_left_q == 14'd0) && pop && head.eop) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop && head.eop) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
  end

  // Skid buffer: pop from the head, then append the arriving word unless it was consumed directly.
  always_comb begin
    logic [1:0] occ_tmp;
    buf_d   = buf_q;
    occ_tmp = occ_q;
    if (pop && (occ_q != 2'd0)) begin
      buf_d[0] = buf_q[1];
      occ_tmp  = occ_q - 2'd1;
    end
    if (inf_q && !(pop && (occ_q == 2'd0))) begin
      buf_d[occ_tmp[0]] = arr_w;
      occ_tmp           = occ_tmp + 2'd1;
    end
    occ_d = occ_tmp;
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q      <= ST_IDLE;
      words_left_q <= '0;
      rem_q        <= '0;
      first_q      <= 1'b0;
      inf_q        <= 1'b0;
      inf_sop_q    <= 1'b0;
      inf_eop_q    <= 1'b0;
      inf_be_q     <= '0;
      buf_q        <= '{default: '0};
      occ_q        <= '0;
      pkt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      rem_q        <= rem_d;
      first_q      <= first_d;
      inf_q        <= inf_d;
      inf_sop_q    <= inf_sop_d;
      inf_eop_q    <= inf_eop_d;
      inf_be_q     <= inf_be_d;
      buf_q        <= buf_d;
      occ_q        <= occ_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

endmodule

// File: tb/tb_x2c_bcnt_reader.sv
// Bench for x2c_bcnt_reader: models both FIFOs as queues, predicts the framed
// output stream per packet and scoreboards every accepted word.
module tb_x2c_bcnt_reader;

  localparam int MAXB = 9600;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        bcnt_empty = 1'b1;
  logic        bcnt_rdreq;
  logic [31:0] bcnt_q = '0;
  logic        data_empty = 1'b1;
  logic        data_rdreq;
  logic [63:0] data_q = '0;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tx_sop;
  logic        tx_eop;
  logic [7:0]  tx_be;
  logic        bcnt_err;
  logic [15:0] pkt_cnt;

  x2c_bcnt_reader #(.DWIDTH(64), .BCW(32), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .reset_(reset_),
    .bcnt_empty(bcnt_empty), .bcnt_rdreq(bcnt_rdreq), .bcnt_q(bcnt_q),
    .data_empty(data_empty), .data_rdreq(data_rdreq), .data_q(data_q),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_be(tx_be),
    .bcnt_err(bcnt_err), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [7:0]  be;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] bq[$];
  logic [63:0] dq[$];

  int checks = 0, errors = 0, cyc = 0;
  int ready_mode = 0, pat_idx = 0, stall_pct = 0;
  bit stall = 0;
  bit [3:0] pat = 4'b1001;
  int n_err_pulses = 0, n_data_reads = 0, n_pops = 0;
  int exp_errs = 0, exp_words = 0, exp_legal = 0;
  bit track_lat = 0;
  int first_brd = -1, first_valid = -1;
  bit s_brd, s_drd, s_pop;
  bit prev_hold = 0;
  logic [63:0] hold_data;
  logic hold_sop, hold_eop;
  logic [7:0] hold_be;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_pkt(int len, bit use_fixed, logic [63:0] w0);
    logic [15:0] rsv;
    int n;
    exp_t e;
    rsv = 16'($urandom());
    bq.push_back({rsv, 16'(len)});
    if (len == 0 || len > MAXB) begin
      exp_errs++;
      return;
    end
    n = (len + 7) / 8;
    exp_words += n;
    exp_legal++;
    for (int i = 0; i < n; i++) begin
      e.data = (use_fixed && i == 0) ? w0 : {$urandom(), $urandom()};
      e.sop  = (i == 0);
      e.eop  = (i == n - 1);
      e.be   = (i == n - 1 && (len % 8) != 0) ? 8'((1 << (len % 8)) - 1) : 8'hFF;
      dq.push_back(e.data);
      exp_q.push_back(e);
    end
  endtask

  // One clock: sample/check at negedge+1, update FIFO models and drive inputs at posedge+1.
  task automatic step();
    exp_t e;
    #1;
    s_brd = bcnt_rdreq;
    s_drd = data_rdreq;
    s_pop = tx_valid & tx_ready;
    if (bcnt_err) n_err_pulses++;
    if (track_lat) begin
      if (bcnt_rdreq && first_brd < 0) first_brd = cyc;
      if (tx_valid && first_valid < 0) first_valid = cyc;
    end
    if (reset_) begin
      if (tx_valid) chk("outstanding_le2", ((n_data_reads - n_pops) <= 2), 1);
      if (prev_hold) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_data", tx_data, hold_data);
        chk("hold_sop", tx_sop, hold_sop);
        chk("hold_eop", tx_eop, hold_eop);
        chk("hold_be", tx_be, hold_be);
      end
      if (s_pop) begin
        chk("word_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("tx_data", tx_data, e.data);
          chk("tx_sop", tx_sop, e.sop);
          chk("tx_eop", tx_eop, e.eop);
          chk("tx_be", tx_be, e.be);
        end
        n_pops++;
      end
      prev_hold = tx_valid & !tx_ready;
      hold_data = tx_data;
      hold_sop  = tx_sop;
      hold_eop  = tx_eop;
      hold_be   = tx_be;
    end else begin
      prev_hold = 0;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (s_brd) begin
      chk("bcnt_rd_nonempty", (bq.size() != 0), 1);
      if (bq.size() != 0) bcnt_q = bq.pop_front();
    end
    if (s_drd) begin
      n_data_reads++;
      chk("data_rd_nonempty", (dq.size() != 0), 1);
      if (dq.size() != 0) data_q = dq.pop_front();
    end
    bcnt_empty = (bq.size() == 0);
    data_empty = (dq.size() == 0) || stall ||
                 (stall_pct != 0 && $urandom_range(0, 99) < stall_pct);
    case (ready_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = 1'($urandom_range(0, 1));
      2: begin tx_ready = pat[pat_idx % 4]; pat_idx++; end
      default: tx_ready = 1'b0;
    endcase
    @(negedge clk);
  endtask

  task automatic drain(int budget);
    int k = 0;
    while ((exp_q.size() != 0 || bq.size() != 0) && k < budget) begin
      step();
      k++;
    end
    chk("drain_within_budget", (k < budget), 1);
    repeat (6) step();
  endtask

  task automatic chk_idle_zero(string tag);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_sop"}, tx_sop, 0);
    chk({tag, "_tx_eop"}, tx_eop, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_tx_be"}, tx_be, 0);
    chk({tag, "_bcnt_rdreq"}, bcnt_rdreq, 0);
    chk({tag, "_data_rdreq"}, data_rdreq, 0);
    chk({tag, "_bcnt_err"}, bcnt_err, 0);
    chk({tag, "_pkt_cnt"}, pkt_cnt, 0);
  endtask

  initial begin
    int base_reads, base_errs, base_pops, k;

    // Reset state
    @(negedge clk);
    reset_ = 1'b0;
    repeat (3) step();
    #1;
    chk_idle_zero("reset");
    reset_ = 1'b1;
    step();

    // Single 8-byte word with latency check
    track_lat = 1;
    base_reads = n_data_reads;
    ready_mode = 0;
    push_pkt(8, 1, 64'h0706050403020100);
    drain(200);
    track_lat = 0;
    chk("lat_rdreq_to_valid", first_valid - first_brd, 3);
    chk("t1_reads", n_data_reads - base_reads, 1);
    chk("t1_pkt_cnt", pkt_cnt, exp_legal);

    // 13 bytes -> two words, last be 1F
    base_reads = n_data_reads;
    push_pkt(13, 0, '0);
    drain(200);
    chk("t2_reads", n_data_reads - base_reads, 2);
    chk("t2_pkt_cnt", pkt_cnt, exp_legal);

    // Illegal counts then a legal 16-byte packet
    base_reads = n_data_reads;
    base_errs  = n_err_pulses;
    push_pkt(0, 0, '0);
    push_pkt(MAXB + 1, 0, '0);
    drain(200);
    chk("t3_err_pulses", n_err_pulses - base_errs, 2);
    chk("t3_no_reads", n_data_reads - base_reads, 0);
    chk("t3_pkt_cnt_same", pkt_cnt, exp_legal);
    push_pkt(16, 0, '0);
    drain(200);
    chk("t3_reads_16", n_data_reads - base_reads, 2);
    chk("t3_pkt_cnt", pkt_cnt, exp_legal);

    // 64 bytes under a 1,0,0,1 ready pattern
    ready_mode = 2;
    pat_idx = 0;
    base_reads = n_data_reads;
    push_pkt(64, 0, '0);
    drain(400);
    chk("t4_reads", n_data_reads - base_reads, 8);
    chk("t4_pkt_cnt", pkt_cnt, exp_legal);

    // Back-to-back 1/9/24 with data_empty pulses
    ready_mode = 0;
    base_reads = n_data_reads;
    push_pkt(1, 0, '0);
    push_pkt(9, 0, '0);
    push_pkt(24, 0, '0);
    repeat (5) step();
    stall = 1; repeat (3) step();
    stall = 0; repeat (3) step();
    stall = 1; repeat (2) step();
    stall = 0;
    drain(400);
    chk("t5_reads", n_data_reads - base_reads, 6);
    chk("t5_pkt_cnt", pkt_cnt, exp_legal);

    // Reset during word 3 of an 8-word packet
    base_pops = n_pops;
    push_pkt(64, 0, '0);
    k = 0;
    while (n_pops - base_pops < 2 && k < 100) begin step(); k++; end
    chk("t6_reach_word3", (k < 100), 1);
    tx_ready   = 1'b0;
    ready_mode = 3;
    reset_     = 1'b0;
    step();
    #1;
    chk_idle_zero("midreset");
    reset_ = 1'b1;
    bq.delete(); dq.delete(); exp_q.delete();
    exp_words = 0; exp_legal = 0; n_data_reads = 0; n_pops = 0;
    ready_mode = 0;
    step();
    push_pkt(8, 1, 64'hA5A5_0123_4567_89AB);
    drain(200);
    chk("t6_reads", n_data_reads, 1);
    chk("t6_pkt_cnt", pkt_cnt, 1);

    // Randomised: max-size packet, then mixed legal/illegal lengths
    ready_mode = 1;
    stall_pct  = 20;
    push_pkt(MAXB, 0, '0);
    drain(20000);
    for (int b = 0; b < 6; b++) begin
      for (int p = 0; p < 4; p++) begin
        int r, len;
        r = $urandom_range(0, 9);
        if (r == 0) len = 0;
        else if (r == 1) len = $urandom_range(MAXB + 1, 65535);
        else len = $urandom_range(1, 120);
        push_pkt(len, 0, '0);
      end
      drain(4000);
    end
    chk("rand_total_reads", n_data_reads, exp_words);
    chk("rand_err_pulses", n_err_pulses, exp_errs);
    chk("rand_pkt_cnt", pkt_cnt, exp_legal);
    chk("rand_data_fifo_empty", dq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
